thread_ibuf: RTL and testbench

Per-thread instruction buffer directly upstream of the dispatcher. It holds one small FIFO per hardware thread, fed by the fetch stage. Each FIFO head is presented as the per-thread opcode/instruction pair the dispatcher arbitrates over. A head is popped when the dispatcher grants that thread an ALU slot.

---
 rtl/thread_ibuf_pkg.sv | 19 +
 rtl/ibuf_fifo.sv | 57 +++++
 rtl/thread_ibuf.sv | 81 ++++++++
 tb/tb_thread_ibuf.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/thread_ibuf_pkg.sv
// Shared types and sizing for the per-thread instruction buffer.
// Optional same-cycle fetch bypass is enabled with THREAD_IBUF_BYPASS_EN.
package thread_ibuf_pkg;

    localparam int NUM_Threads = 4;
    localparam int NUM_ALUs    = 1;
    localparam int IBUF_DEPTH  = 4;

    // Any dispatch code at or above NUM_Threads means "no grant".
    localparam logic [2:0] NO_DISPATCH = 3'd4;
    localparam logic [6:0] OPC_IDLE    = 7'h0;

    typedef logic [31:0] instr_t;

    function automatic logic [6:0] opcode_of(input instr_t ins);
        return ins[6:0];
    endfunction

endpackage

// File: rtl/ibuf_fifo.sv
// Single-thread instruction FIFO.
// Push is ignored when the FIFO is full; pop is ignored when it is empty. Flush empties the queue and wins over both.
module ibuf_fifo
    import thread_ibuf_pkg::*;
#(
    parameter  int DEPTH = IBUF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  instr_t        din,
    input  logic          pop,
    input  logic          flush,
    output instr_t        dout,
    output logic          valid,
    output logic          full,
    output logic [AW:0]   count
);

    instr_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && valid && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Discard everything queued; the write side keeps its position.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/thread_ibuf.sv
// Per-thread instruction buffer feeding the dispatcher: one FIFO per thread, heads exposed as opcode/instruction.
// Define THREAD_IBUF_BYPASS_EN to forward fetch_ins straight to an empty thread's head in the same cycle.
module thread_ibuf
    import thread_ibuf_pkg::*;
#(
    parameter  int DEPTH = IBUF_DEPTH,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_Threads-1:0]              fetch_valid,
    input  logic [NUM_Threads-1:0][31:0]        fetch_ins,
    output logic [NUM_Threads-1:0]              fetch_ready,
    input  logic [NUM_Threads-1:0]              flush,
    input  logic [NUM_ALUs-1:0][2:0]            dispatch_threads,
    output logic [NUM_Threads-1:0][6:0]         oh_out,
    output logic [NUM_Threads-1:0][31:0]        ins_out,
    output logic [NUM_Threads-1:0][CW-1:0]      occupancy,
    output logic                                pop_err
);

    logic [NUM_Threads-1:0] granted;
    logic [NUM_Threads-1:0] push;
    logic [NUM_Threads-1:0] head_valid;
    logic [NUM_Threads-1:0] full;
    logic [NUM_Threads-1:0] consumed;
    logic [NUM_Threads-1:0] bad_grant;
    instr_t                 head [NUM_Threads];

    // Several ALUs naming the same thread still amount to a single pop.
    always_comb begin
        granted = '0;
        for (int t = 0; t < NUM_Threads; t++) begin
            for (int j = 0; j < NUM_ALUs; j++) begin
                if (dispatch_threads[j] == 3'(t)) granted[t] = 1'b1;
            end
        end
    end

    for (genvar t = 0; t < NUM_Threads; t++) begin : g_thread
        logic bypass;

`ifdef THREAD_IBUF_BYPASS_EN
        assign bypass      = !head_valid[t] && fetch_valid[t] && !flush[t];
        assign consumed[t] = bypass && granted[t];
`else
        assign bypass      = 1'b0;
        assign consumed[t] = 1'b0;
`endif
        // A bypassed instruction that is granted at once never enters the queue.
        assign push[t]        = fetch_valid[t] && !consumed[t];
        assign fetch_ready[t] = !full[t];
        assign bad_grant[t]   = granted[t] && !head_valid[t] && !consumed[t];

        ibuf_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[t]),
            .din   (fetch_ins[t]),
            .pop   (granted[t]),
            .flush (flush[t]),
            .dout  (head[t]),
            .valid (head_valid[t]),
            .full  (full[t]),
            .count (occupancy[t])
        );

        always_comb begin
            ins_out[t] = '0;
            if (bypass)             ins_out[t] = fetch_ins[t];
            else if (head_valid[t]) ins_out[t] = head[t];
            oh_out[t] = head_valid[t] || bypass ? opcode_of(ins_out[t]) : OPC_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)             pop_err <= 1'b0;
        else if (|bad_grant) pop_err <= 1'b1;
    end

endmodule

// File: tb/tb_thread_ibuf.sv
// Directed table-driven bench for thread_ibuf, plus hand sequences for bypass timing and reset of pop_err.
module tb_thread_ibuf;

    logic              clk;
    logic              rst;
    logic [3:0]        fetch_valid;
    logic [3:0][31:0]  fetch_ins;
    logic [3:0]        fetch_ready;
    logic [3:0]        flush;
    logic [0:0][2:0]   dispatch_threads;
    logic [3:0][6:0]   oh_out;
    logic [3:0][31:0]  ins_out;
    logic [3:0][2:0]   occupancy;
    logic              pop_err;

    int checks   = 0;
    int failures = 0;

    thread_ibuf dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_valid      (fetch_valid),
        .fetch_ins        (fetch_ins),
        .fetch_ready      (fetch_ready),
        .flush            (flush),
        .dispatch_threads (dispatch_threads),
        .oh_out           (oh_out),
        .ins_out          (ins_out),
        .occupancy        (occupancy),
        .pop_err          (pop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       fv;
        logic [3:0][31:0] fins;
        logic [3:0]       fl;
        logic [2:0]       d;
        logic [3:0][2:0]  e_occ;
        logic [3:0][31:0] e_ins;
        logic             e_err;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(input int pt, input logic [31:0] pi, input logic [3:0] fl,
                                input logic [2:0] d, input int o0, input int o1, input int o2,
                                input int o3, input logic [31:0] i0, input logic [31:0] i1,
                                input logic [31:0] i2, input logic [31:0] i3, input logic err);
        vec_t v;
        v.fv   = '0;
        v.fins = '0;
        if (pt >= 0) begin
            v.fv[pt]   = 1'b1;
            v.fins[pt] = pi;
        end
        v.fl       = fl;
        v.d        = d;
        v.e_occ[0] = 3'(o0);
        v.e_occ[1] = 3'(o1);
        v.e_occ[2] = 3'(o2);
        v.e_occ[3] = 3'(o3);
        v.e_ins[0] = i0;
        v.e_ins[1] = i1;
        v.e_ins[2] = i2;
        v.e_ins[3] = i3;
        v.e_err    = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        fetch_valid         = '0;
        fetch_ins           = '0;
        flush               = '0;
        dispatch_threads[0] = 3'd4;
    endtask

    task automatic check_state(input string tag, input logic [3:0][2:0] e_occ,
                               input logic [3:0][31:0] e_ins, input logic e_err);
        logic [3:0][6:0] e_oh;
        logic [3:0]      e_rdy;
        for (int t = 0; t < 4; t++) begin
            e_oh[t]  = e_ins[t][6:0];
            e_rdy[t] = (e_occ[t] != 3'd4);
        end
        check({tag, " occupancy"}, 128'(occupancy), 128'(e_occ));
        check({tag, " ins_out"}, 128'(ins_out), 128'(e_ins));
        check({tag, " oh_out"}, 128'(oh_out), 128'(e_oh));
        check({tag, " fetch_ready"}, 128'(fetch_ready), 128'(e_rdy));
        check({tag, " pop_err"}, 128'(pop_err), 128'(e_err));
    endtask

    initial begin
        logic [3:0][31:0] zero_ins;
        logic [3:0][2:0]  zero_occ;
        zero_ins = '0;
        zero_occ = '0;

        //           thr ins            fl    d     occ0..3     ins0          ins1          ins2          ins3          err
        vecs[0]  = mk(0, 32'h00A00093, 4'h0, 3'd4, 1, 0, 0, 0, 32'h00A00093, 32'h0,        32'h0,        32'h0,        1'b0);
        vecs[1]  = mk(2, 32'h00100113, 4'h0, 3'd4, 1, 0, 1, 0, 32'h00A00093, 32'h0,        32'h00100113, 32'h0,        1'b0);
        vecs[2]  = mk(2, 32'h00200193, 4'h0, 3'd4, 1, 0, 2, 0, 32'h00A00093, 32'h0,        32'h00100113, 32'h0,        1'b0);
        vecs[3]  = mk(2, 32'h00300213, 4'h0, 3'd4, 1, 0, 3, 0, 32'h00A00093, 32'h0,        32'h00100113, 32'h0,        1'b0);
        vecs[4]  = mk(2, 32'h00400293, 4'h0, 3'd4, 1, 0, 4, 0, 32'h00A00093, 32'h0,        32'h00100113, 32'h0,        1'b0);
        vecs[5]  = mk(2, 32'hDEADBEEF, 4'h0, 3'd4, 1, 0, 4, 0, 32'h00A00093, 32'h0,        32'h00100113, 32'h0,        1'b0);
        vecs[6]  = mk(-1, 32'h0,       4'h0, 3'd2, 1, 0, 3, 0, 32'h00A00093, 32'h0,        32'h00200193, 32'h0,        1'b0);
        vecs[7]  = mk(-1, 32'h0,       4'h0, 3'd2, 1, 0, 2, 0, 32'h00A00093, 32'h0,        32'h00300213, 32'h0,        1'b0);
        vecs[8]  = mk(-1, 32'h0,       4'h0, 3'd2, 1, 0, 1, 0, 32'h00A00093, 32'h0,        32'h00400293, 32'h0,        1'b0);
        vecs[9]  = mk(-1, 32'h0,       4'h0, 3'd2, 1, 0, 0, 0, 32'h00A00093, 32'h0,        32'h0,        32'h0,        1'b0);
        vecs[10] = mk(1, 32'h00500313, 4'h0, 3'd4, 1, 1, 0, 0, 32'h00A00093, 32'h00500313, 32'h0,        32'h0,        1'b0);
        vecs[11] = mk(1, 32'h00600393, 4'h0, 3'd4, 1, 2, 0, 0, 32'h00A00093, 32'h00500313, 32'h0,        32'h0,        1'b0);
        vecs[12] = mk(1, 32'h00700413, 4'h0, 3'd1, 1, 2, 0, 0, 32'h00A00093, 32'h00600393, 32'h0,        32'h0,        1'b0);
        vecs[13] = mk(3, 32'h00800493, 4'h0, 3'd4, 1, 2, 0, 1, 32'h00A00093, 32'h00600393, 32'h0,        32'h00800493, 1'b0);
        vecs[14] = mk(2, 32'h00900513, 4'h0, 3'd4, 1, 2, 1, 1, 32'h00A00093, 32'h00600393, 32'h00900513, 32'h00800493, 1'b0);
        vecs[15] = mk(-1, 32'h0,       4'h0, 3'd4, 1, 2, 1, 1, 32'h00A00093, 32'h00600393, 32'h00900513, 32'h00800493, 1'b0);
        vecs[16] = mk(-1, 32'h0,       4'h0, 3'd3, 1, 2, 1, 0, 32'h00A00093, 32'h00600393, 32'h00900513, 32'h0,        1'b0);
        vecs[17] = mk(-1, 32'h0,       4'h0, 3'd3, 1, 2, 1, 0, 32'h00A00093, 32'h00600393, 32'h00900513, 32'h0,        1'b1);
        vecs[18] = mk(-1, 32'h0,       4'h0, 3'd4, 1, 2, 1, 0, 32'h00A00093, 32'h00600393, 32'h00900513, 32'h0,        1'b1);
        vecs[19] = mk(0, 32'h00B00593, 4'h0, 3'd4, 2, 2, 1, 0, 32'h00A00093, 32'h00600393, 32'h00900513, 32'h0,        1'b1);
        vecs[20] = mk(0, 32'h00C00613, 4'h0, 3'd4, 3, 2, 1, 0, 32'h00A00093, 32'h00600393, 32'h00900513, 32'h0,        1'b1);
        vecs[21] = mk(0, 32'hCAFEF00D, 4'h1, 3'd0, 0, 2, 1, 0, 32'h0,        32'h00600393, 32'h00900513, 32'h0,        1'b1);
        vecs[22] = mk(0, 32'h00D00693, 4'h0, 3'd4, 1, 2, 1, 0, 32'h00D00693, 32'h00600393, 32'h00900513, 32'h0,        1'b1);
        vecs[23] = mk(-1, 32'h0,       4'h0, 3'd0, 0, 2, 1, 0, 32'h0,        32'h00600393, 32'h00900513, 32'h0,        1'b1);

        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_state("reset", zero_occ, zero_ins, 1'b0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            fetch_valid         = vecs[i].fv;
            fetch_ins           = vecs[i].fins;
            flush               = vecs[i].fl;
            dispatch_threads[0] = vecs[i].d;
            @(posedge clk);
            #1 idle();
            #1 check_state($sformatf("vec%0d", i), vecs[i].e_occ, vecs[i].e_ins, vecs[i].e_err);
        end

        // Push into empty thread 3 while granting it in the same cycle.
        @(negedge clk);
        fetch_valid[3]      = 1'b1;
        fetch_ins[3]        = 32'h00E00713;
        dispatch_threads[0] = 3'd3;
        #1;
`ifdef THREAD_IBUF_BYPASS_EN
        check("bypass same-cycle ins_out", 128'(ins_out[3]), 128'(32'h00E00713));
        check("bypass same-cycle oh_out", 128'(oh_out[3]), 128'(7'h13));
`else
        check("no-bypass same-cycle ins_out", 128'(ins_out[3]), 128'(32'h0));
        check("no-bypass same-cycle oh_out", 128'(oh_out[3]), 128'(7'h0));
`endif
        @(posedge clk);
        #1 idle();
        #1;
`ifdef THREAD_IBUF_BYPASS_EN
        check("bypass consumed occupancy", 128'(occupancy[3]), 128'(3'd0));
`else
        check("push+grant empty occupancy", 128'(occupancy[3]), 128'(3'd1));
        check("push+grant empty ins_out", 128'(ins_out[3]), 128'(32'h00E00713));
`endif
        check("pop_err sticky", 128'(pop_err), 128'(1'b1));

        // Only reset clears the sticky error and the queues.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_state("re-reset", zero_occ, zero_ins, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
